// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a 6-digit multiplexed 7-segment bus back to nibbles.
// Optional feature macro: SEG_DECODE_DP_EN (decimal point capture and output).
module seg_scan_decoder #(
  parameter int SETTLE_CYC    = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seg_sel_n,
  input  logic [7:0]  seg_data,
  output logic [23:0] dout,
  output logic [5:0]  dout_mask,
  output logic [5:0]  dout_point_n,
  output logic        dout_vld,
  output logic        pat_err,
  output logic        stall
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] M_FULL = MW'(STABLE_FRAMES);
  localparam logic [IW-1:0] I_MAX  = IW'(TIMEOUT_CYC);

  // {bad, lit, nibble}
  function automatic logic [5:0] seg_dec(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h40:   r = 6'h10;
      7'h79:   r = 6'h11;
      7'h24:   r = 6'h12;
      7'h30:   r = 6'h13;
      7'h19:   r = 6'h14;
      7'h12:   r = 6'h15;
      7'h02:   r = 6'h16;
      7'h78:   r = 6'h17;
      7'h00:   r = 6'h18;
      7'h10:   r = 6'h19;
      7'h08:   r = 6'h1A;
      7'h03:   r = 6'h1B;
      7'h46:   r = 6'h1C;
      7'h21:   r = 6'h1D;
      7'h06:   r = 6'h1E;
      7'h0E:   r = 6'h1F;
      7'h7F:   r = 6'h00;
      default: r = 6'h20;
    endcase
    return r;
  endfunction

  logic [5:0]    sel_q, sel_p_q;
  logic [6:0]    seg_q;
  logic          dp_in;
  logic [SW-1:0] settle_q, settle_d;
  logic          done_q, done_d;
  logic [5:0]    seen_q, seen_d;
  logic [23:0]   nib_q, nib_d;
  logic [5:0]    msk_q, msk_d;
  logic [5:0]    dpf_q, dpf_d;
  logic          err_q, err_d;
  logic [35:0]   prev_q, prev_d;
  logic [MW-1:0] match_q, match_d;
  logic          pub_q, pub_d;
  logic [23:0]   dout_q, dout_d;
  logic [5:0]    mask_q, mask_d;
  logic [5:0]    pt_q, pt_d;
  logic          vld_q, vld_d;
  logic          perr_q, perr_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          stall_q, stall_d;

  logic [5:0]    sel_lo;
  logic          valid, chg, smp, fdone, ferr;
  logic [SW-1:0] cnt_e;
  logic [2:0]    idx;
  logic [5:0]    dec;
  logic [35:0]   frm;

`ifdef SEG_DECODE_DP_EN
  logic dpi_q;
  // Capture the raw decimal point alongside the segments
  always_ff @(posedge clk) begin
    if (rst) dpi_q <= 1'b1;
    else     dpi_q <= seg_data[7];
  end
  assign dp_in = dpi_q;
`else
  logic unused_dp;
  assign unused_dp = seg_data[7];
  assign dp_in     = 1'b1;
`endif

  // Qualify select, settle, sample and assemble frames
  always_comb begin
    sel_lo  = ~sel_q;
    valid   = (sel_lo != 6'd0) && ((sel_lo & (sel_lo - 6'd1)) == 6'd0);
    chg     = sel_q != sel_p_q;
    cnt_e   = chg ? '0 : settle_q;
    smp     = valid && !done_q && (cnt_e == S_LAST);
    settle_d = '0;
    if (valid) settle_d = (cnt_e == S_LAST) ? cnt_e : cnt_e + SW'(1);
    done_d  = smp | (done_q & valid & ~chg);

    idx = 3'd0;
    for (int i = 0; i < 6; i++)
      if (sel_lo[i]) idx = 3'(i);
    dec = seg_dec(seg_q);

    nib_d  = nib_q;
    msk_d  = msk_q;
    dpf_d  = dpf_q;
    seen_d = seen_q;
    err_d  = err_q;
    if (smp) begin
      nib_d[4*int'(idx) +: 4] = dec[3:0];
      msk_d[idx] = dec[4];
      dpf_d[idx] = dp_in;
      seen_d     = seen_q | sel_lo;
      err_d      = err_q | dec[5];
    end
    fdone = smp && (seen_d == 6'h3F);
    ferr  = err_d;
    frm   = {nib_d, msk_d, dpf_d};
    if (fdone) begin
      seen_d = 6'd0;
      err_d  = 1'b0;
    end
  end

  // Stability tracking, publish and error pulse
  always_comb begin
    prev_d  = prev_q;
    match_d = match_q;
    pub_d   = pub_q;
    dout_d  = dout_q;
    mask_d  = mask_q;
    pt_d    = pt_q;
    vld_d   = 1'b0;
    perr_d  = 1'b0;
    if (fdone) begin
      if (ferr) begin
        perr_d  = 1'b1;
        match_d = '0;
      end else begin
        prev_d = frm;
        if (frm == prev_q)
          match_d = (match_q == M_FULL) ? match_q : match_q + MW'(1);
        else
          match_d = MW'(1);
        if (match_d == M_FULL &&
            (!pub_q || frm != {dout_q, mask_q, pt_q})) begin
          dout_d = nib_d;
          mask_d = msk_d;
          pt_d   = dpf_d;
          vld_d  = 1'b1;
          pub_d  = 1'b1;
        end
      end
    end
  end

  // Idle watchdog: stall after TIMEOUT_CYC cycles without a sample
  always_comb begin
    idle_d  = idle_q;
    stall_d = stall_q;
    if (smp) begin
      idle_d  = '0;
      stall_d = 1'b0;
    end else if (idle_q != I_MAX) begin
      idle_d = idle_q + IW'(1);
      if (idle_d == I_MAX) stall_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 6'h3F;
      sel_p_q  <= 6'h3F;
      seg_q    <= 7'h7F;
      settle_q <= '0;
      done_q   <= 1'b0;
      seen_q   <= 6'd0;
      nib_q    <= 24'd0;
      msk_q    <= 6'd0;
      dpf_q    <= 6'h3F;
      err_q    <= 1'b0;
      prev_q   <= '0;
      match_q  <= '0;
      pub_q    <= 1'b0;
      dout_q   <= 24'd0;
      mask_q   <= 6'd0;
      pt_q     <= 6'h3F;
      vld_q    <= 1'b0;
      perr_q   <= 1'b0;
      idle_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      sel_q    <= seg_sel_n;
      sel_p_q  <= sel_q;
      seg_q    <= seg_data[6:0];
      settle_q <= settle_d;
      done_q   <= done_d;
      seen_q   <= seen_d;
      nib_q    <= nib_d;
      msk_q    <= msk_d;
      dpf_q    <= dpf_d;
      err_q    <= err_d;
      prev_q   <= prev_d;
      match_q  <= match_d;
      pub_q    <= pub_d;
      dout_q   <= dout_d;
      mask_q   <= mask_d;
      pt_q     <= pt_d;
      vld_q    <= vld_d;
      perr_q   <= perr_d;
      idle_q   <= idle_d;
      stall_q  <= stall_d;
    end
  end

  assign dout         = dout_q;
  assign dout_mask    = mask_q;
  assign dout_point_n = pt_q;
  assign dout_vld     = vld_q;
  assign pat_err      = perr_q;
  assign stall        = stall_q;

endmodule
